// File: rtl/decode_issue_queue.sv
// In-order decode-to-issue queue with a branch-resolution gate on issue.
// Optional DECODE_ISSUE_QUEUE_BYPASS_EN adds a zero-latency bypass when the queue is empty.
module decode_issue_queue #(
    parameter type               cva6_cfg_t         = logic [31:0],
    parameter cva6_cfg_t         CVA6Cfg            = '0,
    parameter type               scoreboard_entry_t = logic [63:0],
    parameter int unsigned       DEPTH              = 4,
    localparam int unsigned      CNT_W              = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  scoreboard_entry_t instr_i,
    input  logic              instr_is_ctrl_flow_i,
    input  logic              instr_valid_i,
    output logic              instr_ready_o,
    output scoreboard_entry_t decoded_instr_o,
    output logic              decoded_instr_valid_o,
    output logic              is_ctrl_flow_o,
    input  logic              decoded_instr_ack_i,
    input  logic              resolve_branch_i,
    output logic [CNT_W-1:0]  count_o,
    output logic              wait_branch_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {StIdle, StWaitResolve} state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    scoreboard_entry_t mem_q [DEPTH];
    logic [DEPTH-1:0]  ctrl_q;

    logic gate_open, bypass_active, head_ctrl;
    logic push, pop, store_push, store_pop;
    logic unused_cfg;

    assign unused_cfg = ^CVA6Cfg;

    assign instr_ready_o = (count_q != CNT_W'(DEPTH));
    assign push          = instr_valid_i & instr_ready_o & ~flush_i;
    assign count_o       = count_q;

    // FSM output process
    always_comb begin
        gate_open     = 1'b0;
        wait_branch_o = 1'b0;
        unique case (state_q)
            StIdle:        gate_open     = 1'b1;
            StWaitResolve: wait_branch_o = 1'b1;
            default:       gate_open     = 1'b0;
        endcase
    end

    always_comb begin
        decoded_instr_o       = mem_q[rd_ptr_q];
        head_ctrl             = ctrl_q[rd_ptr_q];
        decoded_instr_valid_o = gate_open & (count_q != '0);
        bypass_active         = 1'b0;
`ifdef DECODE_ISSUE_QUEUE_BYPASS_EN
        if (gate_open && (count_q == '0) && instr_valid_i) begin
            bypass_active         = 1'b1;
            decoded_instr_o       = instr_i;
            head_ctrl             = instr_is_ctrl_flow_i;
            decoded_instr_valid_o = 1'b1;
        end
`endif
        // Storage is not reset, so mask the flag while nothing is presented.
        is_ctrl_flow_o = decoded_instr_valid_o & head_ctrl;
    end

    assign pop = decoded_instr_valid_o & decoded_instr_ack_i & ~flush_i;

    // A bypassed entry consumed in the same cycle never touches storage.
    assign store_push = push & ~(bypass_active & decoded_instr_ack_i);
    assign store_pop  = pop & ~bypass_active;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (store_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (store_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (store_push && !store_pop)      count_d = count_q + CNT_W'(1);
            else if (!store_push && store_pop) count_d = count_q - CNT_W'(1);
        end
    end

    // FSM next-state process
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:        if (pop && is_ctrl_flow_o) state_d = StWaitResolve;
                StWaitResolve: if (resolve_branch_i) state_d = StIdle;
                default:       state_d = StIdle;
            endcase
        end
    end

    // FSM state register and pointers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (store_push) begin
            mem_q[wr_ptr_q]  <= instr_i;
            ctrl_q[wr_ptr_q] <= instr_is_ctrl_flow_i;
        end
    end

endmodule

// File: tb/tb_decode_issue_queue.sv
// Self-checking bench for decode_issue_queue: directed scenarios plus random traffic,
// all compared cycle by cycle against a queue-based reference model.
module tb_decode_issue_queue;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] op;
    } sbe_t;

    typedef struct {
        logic [31:0] pc;
        bit          ctrl;
    } ment_t;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] OP_KEY = 32'hdead_beef;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush_i;
    sbe_t       instr_i;
    logic       instr_is_ctrl_flow_i;
    logic       instr_valid_i;
    logic       instr_ready_o;
    sbe_t       decoded_instr_o;
    logic       decoded_instr_valid_o;
    logic       is_ctrl_flow_o;
    logic       decoded_instr_ack_i;
    logic       resolve_branch_i;
    logic [2:0] count_o;
    logic       wait_branch_o;

    int n_checks = 0;
    int n_fail   = 0;

    ment_t mq[$];
    bit    m_wait;

    always #5 clk = ~clk;

    decode_issue_queue #(
        .scoreboard_entry_t(sbe_t),
        .DEPTH             (DEPTH)
    ) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .flush_i              (flush_i),
        .instr_i              (instr_i),
        .instr_is_ctrl_flow_i (instr_is_ctrl_flow_i),
        .instr_valid_i        (instr_valid_i),
        .instr_ready_o        (instr_ready_o),
        .decoded_instr_o      (decoded_instr_o),
        .decoded_instr_valid_o(decoded_instr_valid_o),
        .is_ctrl_flow_o       (is_ctrl_flow_o),
        .decoded_instr_ack_i  (decoded_instr_ack_i),
        .resolve_branch_i     (resolve_branch_i),
        .count_o              (count_o),
        .wait_branch_o        (wait_branch_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: called just after a rising edge, checks mid-cycle, updates model after edge.
    task automatic cycle(input bit v, input bit c, input logic [31:0] pc,
                         input bit ack, input bit res, input bit fl);
        bit          byp, ev, er, pop, push, ectrl;
        logic [31:0] epc;
        ment_t       e;
        instr_valid_i        = v;
        instr_is_ctrl_flow_i = c;
        instr_i.pc           = pc;
        instr_i.op           = pc ^ OP_KEY;
        decoded_instr_ack_i  = ack;
        resolve_branch_i     = res;
        flush_i              = fl;
        #4;
        er  = (mq.size() != DEPTH);
        ev  = (mq.size() != 0) && !m_wait;
        byp = 1'b0;
`ifdef DECODE_ISSUE_QUEUE_BYPASS_EN
        byp = (mq.size() == 0) && !m_wait && v;
`endif
        ev    = ev | byp;
        ectrl = 1'b0;
        epc   = '0;
        if (byp) begin
            epc   = pc;
            ectrl = c;
        end else if (ev) begin
            epc   = mq[0].pc;
            ectrl = mq[0].ctrl;
        end
        chk("ready", 32'(instr_ready_o), 32'(er));
        chk("valid", 32'(decoded_instr_valid_o), 32'(ev));
        chk("count", 32'(count_o), 32'(mq.size()));
        chk("wait_branch", 32'(wait_branch_o), 32'(m_wait));
        chk("ctrl_flow", 32'(is_ctrl_flow_o), 32'(ectrl));
        if (ev) begin
            chk("head_pc", decoded_instr_o.pc, epc);
            chk("head_op", decoded_instr_o.op, epc ^ OP_KEY);
        end
        @(posedge clk);
        #1;
        if (fl) begin
            mq.delete();
            m_wait = 1'b0;
        end else begin
            pop  = ev && ack;
            push = v && er;
            if (!(byp && ack)) begin
                if (pop) void'(mq.pop_front());
                if (push) begin
                    e.pc   = pc;
                    e.ctrl = c;
                    mq.push_back(e);
                end
            end
            if (pop && ectrl)        m_wait = 1'b1;
            else if (m_wait && res)  m_wait = 1'b0;
        end
    endtask

    initial begin
        rst                  = 1'b1;
        flush_i              = 1'b0;
        instr_i              = '0;
        instr_is_ctrl_flow_i = 1'b0;
        instr_valid_i        = 1'b0;
        decoded_instr_ack_i  = 1'b0;
        resolve_branch_i     = 1'b0;
        m_wait               = 1'b0;
        #2;
        chk("rst_ready", 32'(instr_ready_o), 32'd1);
        chk("rst_valid", 32'(decoded_instr_valid_o), 32'd0);
        chk("rst_ctrl", 32'(is_ctrl_flow_o), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_wait", 32'(wait_branch_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Fill: five pushes against a four-entry queue, then drain in order.
        for (int i = 0; i < 5; i++) cycle(1, 0, 32'h100 + 32'(4 * i), 0, 0, 0);
        chk("fill_count", 32'(count_o), 32'd4);
        chk("fill_ready", 32'(instr_ready_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc", decoded_instr_o.pc, 32'h100 + 32'(4 * i));
            cycle(0, 0, 32'h0, 1, 0, 0);
        end
        chk("drain_count", 32'(count_o), 32'd0);

        // Simultaneous push/pop at count 2, wrapping the pointers.
        cycle(1, 0, 32'h400, 0, 0, 0);
        cycle(1, 0, 32'h404, 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle(1, 0, 32'h408 + 32'(4 * i), 1, 0, 0);
        chk("simul_count", 32'(count_o), 32'd2);
        cycle(0, 0, 32'h0, 1, 0, 0);
        cycle(0, 0, 32'h0, 1, 0, 0);

        // Branch gate.
        cycle(1, 1, 32'h200, 0, 0, 0);
        cycle(1, 0, 32'h204, 0, 0, 0);
        cycle(0, 0, 32'h0, 1, 0, 0);
        chk("br_wait", 32'(wait_branch_o), 32'd1);
        chk("br_valid", 32'(decoded_instr_valid_o), 32'd0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 32'h0, 1, 0, 0);
        cycle(0, 0, 32'h0, 0, 1, 0);
        chk("br_resume_pc", decoded_instr_o.pc, 32'h204);
        cycle(0, 0, 32'h0, 1, 0, 0);

        // Flush while waiting on a branch with three entries queued.
        cycle(1, 1, 32'h600, 0, 0, 0);
        cycle(1, 0, 32'h604, 0, 0, 0);
        cycle(1, 0, 32'h608, 0, 0, 0);
        cycle(1, 1, 32'h600, 1, 0, 0);
        cycle(1, 0, 32'h60c, 0, 0, 1);
        chk("flush_count", 32'(count_o), 32'd0);
        chk("flush_wait", 32'(wait_branch_o), 32'd0);
        cycle(0, 0, 32'h0, 0, 0, 0);

        // Asynchronous reset between edges with two entries held.
        cycle(1, 0, 32'h500, 0, 0, 0);
        cycle(1, 0, 32'h504, 0, 0, 0);
        instr_valid_i = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(decoded_instr_valid_o), 32'd0);
        chk("arst_count", 32'(count_o), 32'd0);
        chk("arst_ready", 32'(instr_ready_o), 32'd1);
        #1;
        rst = 1'b0;
        mq.delete();
        m_wait = 1'b0;
        @(posedge clk);
        #1;

        // Empty-queue push with ack: same-cycle with bypass, next cycle without.
        cycle(1, 0, 32'h300, 1, 0, 0);
        cycle(0, 0, 32'h0, 1, 0, 0);
        cycle(0, 0, 32'h0, 0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 25,
                  {$urandom_range(0, 16'hffff), 2'b00} , $urandom_range(0, 99) < 60,
                  $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 4);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_issue_queue.md
Name: decode_issue_queue

Overview:
Small in-order instruction queue between the decoder and the issue stage. It decouples decoder throughput from issue backpressure, and holds back further issue after a control-flow instruction until the branch unit reports resolution. It presents scoreboard entries to the issue stage's decoded-instruction valid/ack interface, together with a per-entry control-flow flag.

Parameters:
CVA6Cfg, config_pkg::cva6_cfg_empty, core configuration; passed through, no local use beyond types.
DEPTH, 4, number of queue entries; power of two, >= 2.
CNT_W, $clog2(DEPTH+1), occupancy counter width; derived, not overridable.

Ports:
clk_i  in  1  clock.
rst_i  in  1  reset; asynchronous, active-high.
flush_i  in  1  discard all queued entries and clear branch wait.
instr_i  in  scoreboard_entry_t  decoded instruction from the decoder.
instr_is_ctrl_flow_i  in  1  instr_i is a branch/jump.
instr_valid_i  in  1  instr_i valid.
instr_ready_o  out  1  queue can accept instr_i this cycle.
decoded_instr_o  out  scoreboard_entry_t  head entry to the issue stage.
decoded_instr_valid_o  out  1  head entry valid for issue.
is_ctrl_flow_o  out  1  head entry is control flow.
decoded_instr_ack_i  in  1  issue stage accepted the head entry.
resolve_branch_i  in  1  outstanding control-flow instruction resolved.
count_o  out  CNT_W  current occupancy.
wait_branch_o  out  1  FSM in WAIT_RESOLVE (for performance counters).

Behaviour:
- Reset (rst_i=1, asynchronous): rd/wr pointers=0, count=0, FSM=IDLE.
  - Reset values: instr_ready_o=1, decoded_instr_valid_o=0, is_ctrl_flow_o=0, count_o=0, wait_branch_o=0. decoded_instr_o content is don't-care while invalid.
  - Storage array is not reset.
- Storage: DEPTH entries, each holding {scoreboard_entry_t, ctrl_flow bit}. First-word fall-through: the head is driven from storage[rd_ptr].
- instr_ready_o = (count != DEPTH). It has no combinational dependence on decoded_instr_ack_i, so a full queue with a simultaneous pop still deasserts ready.
- push = instr_valid_i & instr_ready_o & ~flush_i. On push, write storage[wr_ptr] and advance wr_ptr.
- decoded_instr_valid_o = (count != 0) & (FSM == IDLE).
- pop = decoded_instr_valid_o & decoded_instr_ack_i & ~flush_i. On pop, advance rd_ptr.
- ack_i while valid_o=0 is ignored.
- Pointers wrap modulo DEPTH.
- Count update: push only -> count+1; pop only -> count-1; push and pop together -> count unchanged.
- Minimum latency (optional feature off): 1 cycle from push to decoded_instr_valid_o.
- FSM, two states:
  - IDLE: a pop of an entry with ctrl_flow=1 -> WAIT_RESOLVE (next cycle).
  - WAIT_RESOLVE: decoded_instr_valid_o forced 0 and pushes still accepted. resolve_branch_i=1 -> IDLE, so the next entry can be valid in the following cycle.
  - resolve_branch_i in IDLE is ignored.
  - A pop of a ctrl-flow entry and resolve_branch_i in the same cycle still enters WAIT_RESOLVE; the resolve is not credited.
- flush_i (synchronous): next cycle count=0, pointers=0, FSM=IDLE. A push or pop in the flush cycle is discarded. Flush has priority over all other events. flush_i and rst_i together: reset wins.
- wait_branch_o = (FSM == WAIT_RESOLVE).
- Outputs are stable while valid_o=1 and ack_i=0; the head entry never changes without a pop or flush.

Optional Feature:
DECODE_ISSUE_QUEUE_BYPASS_EN
- Defined: when count==0 and FSM==IDLE and instr_valid_i=1, instr_i and instr_is_ctrl_flow_i drive the outputs combinationally and decoded_instr_valid_o=1 in the same cycle.
  - If acked in that cycle, the entry is not written; pointers and count are unchanged, and the ctrl-flow FSM transition still applies.
  - If not acked, it is pushed normally.
  - Latency becomes 0 cycles.
- Undefined: no combinational path from instr_* to decoded_instr_*; latency is 1 cycle.

Test Plan:
- Fill: DEPTH=4, ack_i held 0, push 5 back-to-back entries (pc 0x100..0x110) -> instr_ready_o drops after the 4th, count_o=4, 5th not accepted. Then ack_i=1 for 4 cycles -> outputs pc 0x100,0x104,0x108,0x10C in order, count_o returns to 0.
- Simultaneous: count=2, push and pop in the same cycle -> count_o stays 2, FIFO order preserved; also wrap rd/wr pointers past index 3 with correct data.
- Branch gate: queue {br@0x200 ctrl=1, add@0x204}; ack br -> next cycle valid_o=0, wait_branch_o=1. Hold 3 cycles, then resolve_branch_i=1 -> following cycle valid_o=1 with pc 0x204.
- Flush: count=3, FSM=WAIT_RESOLVE, flush_i with push in the same cycle -> next cycle count_o=0, valid_o=0, wait_branch_o=0, ready_o=1, pushed entry absent.
- Reset mid-operation: count=2, assert rst_i asynchronously between clock edges -> valid_o=0 and count_o=0 immediately, without a clock edge.
- Bypass (macro defined): empty queue, push pc 0x300 with ack_i=1 -> valid_o=1 and pc 0x300 the same cycle, count_o stays 0. Macro undefined: same stimulus -> valid_o=0 that cycle, 1 the next.
